// File: rtl/csr_unit.sv
// Sequential Zicsr access unit: reads the addressed CSR, issues the RW/RS/RC write,
// and returns the old value through a valid/ready response port.
module csr_unit #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [11:0]     req_addr,
  input  logic [XLEN-1:0] req_src,
  input  logic [4:0]      req_rs1,
  input  logic [4:0]      req_rd,
  output logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_rdata,
  output logic            csr_wen,
  output logic [XLEN-1:0] csr_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_we,
  output logic            resp_illegal
);

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [1:0]      op_reg;
  logic [11:0]     addr_reg;
  logic [XLEN-1:0] src_reg;
  logic [4:0]      rs1_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] old_reg;

  logic            accept;
  logic            wr;
  logic            illegal;
  logic [XLEN-1:0] new_val;

  assign accept = (state_reg == IDLE) && req_valid;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured only on acceptance; old value only at the end of READ
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_reg   <= 2'b00;
      addr_reg <= 12'h000;
      src_reg  <= '0;
      rs1_reg  <= 5'd0;
      rd_reg   <= 5'd0;
      old_reg  <= '0;
    end else begin
      if (accept) begin
        op_reg   <= req_op;
        addr_reg <= req_addr;
        src_reg  <= req_src;
        rs1_reg  <= req_rs1;
        rd_reg   <= req_rd;
      end
      if (state_reg == READ) begin
        old_reg <= csr_rdata;
      end
    end
  end

  // Set/clear with a zero rs1/uimm field must not write, so read-only CSRs stay readable
  always_comb begin
    wr = 1'b0;
    case (op_reg)
      OP_RW:        wr = 1'b1;
      OP_RS, OP_RC: wr = (rs1_reg != 5'd0);
      default:      wr = 1'b0;
    endcase
    illegal = (op_reg == 2'b00) || (wr && (addr_reg[11:10] == 2'b11));
  end

  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_new_bit
      always_comb begin
        new_val[gi] = old_reg[gi];
        case (op_reg)
          OP_RW:   new_val[gi] = src_reg[gi];
          OP_RS:   new_val[gi] = old_reg[gi] | src_reg[gi];
          OP_RC:   new_val[gi] = old_reg[gi] & ~src_reg[gi];
          default: new_val[gi] = old_reg[gi];
        endcase
      end
    end
  endgenerate

  // Outputs decode straight from state so reset removes the write strobe at once
  always_comb begin
    req_ready    = (state_reg == IDLE);
    csr_addr     = addr_reg;
    csr_wen      = 1'b0;
    csr_wdata    = '0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_rd      = rd_reg;
    resp_we      = 1'b0;
    resp_illegal = 1'b0;
    case (state_reg)
      WRITE: begin
        csr_wen   = wr && !illegal;
        csr_wdata = new_val;
      end
      RESP: begin
        resp_valid   = 1'b1;
        resp_rdata   = illegal ? '0 : old_reg;
        resp_we      = !illegal && (rd_reg != 5'd0);
        resp_illegal = illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit with a CSR-file stub and a response scoreboard.
module tb_csr_unit;

  localparam logic [1:0] OP_RSV = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [31:0] req_src;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rd;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        resp_illegal;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } resp_t;

  resp_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // CSR file stub: combinational read, write on clock edge, bench preload port
  logic [31:0] stub_mem [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = 12'h000;
  logic [31:0] pl_data = 32'h0;

  assign csr_rdata = stub_mem[csr_addr];

  always @(posedge clock) begin
    if (pl_en) stub_mem[pl_addr] <= pl_data;
    else if (csr_wen) stub_mem[csr_addr] <= csr_wdata;
  end

  always #5 clock = ~clock;

  csr_unit #(.XLEN(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_src      (req_src),
    .req_rs1      (req_rs1),
    .req_rd       (req_rd),
    .csr_addr     (csr_addr),
    .csr_rdata    (csr_rdata),
    .csr_wen      (csr_wen),
    .csr_wdata    (csr_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_rd      (resp_rd),
    .resp_we      (resp_we),
    .resp_illegal (resp_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clock);
    pl_en   = 1'b1;
    pl_addr = addr;
    pl_data = data;
    @(posedge clock);
    #1;
    pl_en = 1'b0;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic [4:0] rs1, input logic [4:0] rd, input logic [31:0] old,
                         input logic exp_wen, input logic [31:0] exp_wdata, input logic exp_ill,
                         input int stall);
    resp_t e;
    resp_t got;
    preload(addr, old);
    e.rdata = exp_ill ? 32'h0 : old;
    e.rd    = rd;
    e.we    = !exp_ill && (rd != 5'd0);
    e.ill   = exp_ill;
    sb.push_back(e);

    @(negedge clock);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_src   = src;
    req_rs1   = rs1;
    req_rd    = rd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = 12'($urandom);
    req_src   = $urandom;
    req_rs1   = 5'($urandom);
    req_rd    = 5'($urandom);
    chk("read_req_ready", req_ready, 0);
    chk("read_csr_addr", csr_addr, addr);
    chk("read_csr_wen", csr_wen, 0);
    @(posedge clock);
    #1;
    chk("write_csr_wen", csr_wen, exp_wen);
    if (exp_wen) chk("write_csr_wdata", csr_wdata, exp_wdata);
    @(posedge clock);
    #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_csr_wen", csr_wen, 0);
    n_cmp++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL sb_underflow: observed=0 expected=1");
    end
    got = (sb.size() > 0) ? sb.pop_front() : e;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_op    = OP_RW;
      req_addr  = 12'h7FF;
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_rdata", resp_rdata, got.rdata);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_csr_addr", csr_addr, addr);
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    chk("resp_rdata", resp_rdata, got.rdata);
    chk("resp_rd", resp_rd, got.rd);
    chk("resp_we", resp_we, got.we);
    chk("resp_illegal", resp_illegal, got.ill);
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    chk("hs_req_ready", req_ready, 1);
    chk("hs_resp_valid", resp_valid, 0);
    chk("stub_value", stub_mem[addr], exp_wen ? exp_wdata : old);
    $display("txn op=%b addr=%h src=%h rd=%0d -> rdata=%h we=%b ill=%b stub=%h",
             op, addr, src, rd, got.rdata, got.we, got.ill, stub_mem[addr]);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_addr   = 12'h000;
    req_src    = 32'h0;
    req_rs1    = 5'd0;
    req_rd     = 5'd0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_csr_addr", csr_addr, 0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("idle_ready", req_ready, 1);
      chk("idle_wen", csr_wen, 0);
      chk("idle_resp_valid", resp_valid, 0);
      chk("idle_resp_rdata", resp_rdata, 0);
    end

    // Read-only CSR read without write intent is legal
    run_req(OP_RS, 12'hF11, 32'h0, 5'd0, 5'd5, 32'h616B6562, 1'b0, 32'h0, 1'b0, 0);
    run_req(OP_RW, 12'h340, 32'hDEADBEEF, 5'd1, 5'd0, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 0);
    run_req(OP_RC, 12'h341, 32'h0000FF00, 5'd3, 5'd7, 32'hFFFFFFFF, 1'b1, 32'hFFFF00FF, 1'b0, 0);
    run_req(OP_RS, 12'h342, 32'h00000001, 5'd1, 5'd8, 32'h00000010, 1'b1, 32'h00000011, 1'b0, 0);
    run_req(OP_RC, 12'h343, 32'hFFFFFFFF, 5'd0, 5'd6, 32'h0000ABCD, 1'b0, 32'h0, 1'b0, 0);
    run_req(OP_RW, 12'hF12, 32'h00000077, 5'd2, 5'd4, 32'h00000055, 1'b0, 32'h0, 1'b1, 0);
    run_req(OP_RSV, 12'h340, 32'h00000001, 5'd1, 5'd9, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 0);
    run_req(OP_RS, 12'h300, 32'h00000008, 5'd2, 5'd10, 32'h00000001, 1'b1, 32'h00000009, 1'b0, 5);

    // Reset during WRITE must abort the write and discard the response
    preload(12'h305, 32'h11111111);
    @(negedge clock);
    req_valid = 1'b1;
    req_op    = OP_RW;
    req_addr  = 12'h305;
    req_src   = 32'hCAFEF00D;
    req_rs1   = 5'd1;
    req_rd    = 5'd2;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("mr_wen_before", csr_wen, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_csr_wen", csr_wen, 0);
    chk("mr_csr_wdata", csr_wdata, 0);
    chk("mr_csr_addr", csr_addr, 0);
    chk("mr_resp_valid", resp_valid, 0);
    chk("mr_resp_rdata", resp_rdata, 0);
    chk("mr_resp_rd", resp_rd, 0);
    chk("mr_resp_we", resp_we, 0);
    chk("mr_resp_illegal", resp_illegal, 0);
    @(posedge clock);
    #1;
    chk("mr_stub_unchanged", stub_mem[12'h305], 32'h11111111);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("mr_ready_after", req_ready, 1);
    chk("mr_valid_after", resp_valid, 0);
    $display("txn mid-operation reset addr=305 stub=%h", stub_mem[12'h305]);

    run_req(OP_RS, 12'h305, 32'h00000002, 5'd1, 5'd3, 32'h11111111, 1'b1, 32'h11111113, 1'b0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
